adc_channel_arbiter: RTL and testbench



---
 rtl/adc_channel_arbiter_if.sv | 12 +
 rtl/adc_channel_arbiter.sv | 155 +++++++++++++++
 tb/tb_adc_channel_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_channel_arbiter_if.sv
// Requester-side bundle of adc_channel_arbiter: level requests in, tagged results out.
interface adc_channel_arbiter_if #(parameter int NUM_REQ = 3);
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_ch;
    logic [NUM_REQ-1:0]   res_valid;
    logic [11:0]          res_data;
    logic [2:0]           res_ch;
    logic                 busy;

    modport master (output req, req_ch, input res_valid, res_data, res_ch, busy);
    modport slave  (input req, req_ch, output res_valid, res_data, res_ch, busy);
endinterface

// File: rtl/adc_channel_arbiter.sv
// Round-robin sharing of one ADC128S022 among NUM_REQ requesters. The ADC returns
// frame N's data for frame N-1's address, so each result is tagged one frame late.
module adc_channel_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                  adc_sck,
    input  logic                  rst_n,
    adc_channel_arbiter_if.slave  rif,
    output logic                  adc_cs_n,
    output logic                  din,
    input  logic                  dout
);
    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, FRAME} state_t;
    typedef struct packed {
        logic          v;
        logic [TW-1:0] tag;
        logic [2:0]    ch;
    } slot_t;

    state_t             state, state_nxt;
    logic [3:0]         bit_cnt, bit_cnt_nxt;
    logic [2:0]         addr, addr_nxt;
    slot_t              cur, cur_nxt, prev, prev_nxt;
    logic [TW-1:0]      last_grant, last_grant_nxt;
    logic [11:0]        shreg;
    logic               boundary, strobe, din_nxt;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_found;
    logic [TW-1:0]      gnt_tag;
    logic [2:0]         gnt_ch;

    assign boundary = (state == FRAME) && (bit_cnt == 4'd15);
    assign strobe   = boundary && prev.v;
    assign rif.busy = (state == FRAME);

    // A requester already in flight, or being answered on this edge, must sit out.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = rif.req[i]
                   && !(cur.v && cur.tag == TW'(i))
                   && !(strobe && prev.tag == TW'(i));
    end

    // Two descending passes, later write wins: the lowest index above last_grant
    // beats everything, otherwise the lowest index at or below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_tag   = '0;
        gnt_ch    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (elig[i] && TW'(i) <= last_grant) begin
                gnt_found = 1'b1;
                gnt_tag   = TW'(i);
                gnt_ch    = rif.req_ch[3*i +: 3];
            end
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (elig[i] && TW'(i) > last_grant) begin
                gnt_found = 1'b1;
                gnt_tag   = TW'(i);
                gnt_ch    = rif.req_ch[3*i +: 3];
            end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        addr_nxt       = addr;
        cur_nxt        = cur;
        prev_nxt       = prev;
        last_grant_nxt = last_grant;
        din_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_nxt      = FRAME;
                    bit_cnt_nxt    = 4'd0;
                    cur_nxt        = '{v: 1'b1, tag: gnt_tag, ch: gnt_ch};
                    prev_nxt.v     = 1'b0;
                    addr_nxt       = gnt_ch;
                    last_grant_nxt = gnt_tag;
                end
            end
            FRAME: begin
                if (boundary) begin
                    prev_nxt    = cur;
                    bit_cnt_nxt = 4'd0;
                    if (gnt_found) begin
                        cur_nxt        = '{v: 1'b1, tag: gnt_tag, ch: gnt_ch};
                        addr_nxt       = gnt_ch;
                        last_grant_nxt = gnt_tag;
                    end else if (cur.v) begin
                        // Flush frame: re-send the in-flight address to clock its data out.
                        cur_nxt.v = 1'b0;
                        addr_nxt  = cur.ch;
                    end else begin
                        cur_nxt.v = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == FRAME) begin
            case (bit_cnt_nxt)
                4'd2:    din_nxt = addr_nxt[2];
                4'd3:    din_nxt = addr_nxt[1];
                4'd4:    din_nxt = addr_nxt[0];
                default: din_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(negedge adc_sck or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            addr          <= 3'd0;
            cur           <= '0;
            prev          <= '0;
            last_grant    <= TW'(NUM_REQ - 1);
            adc_cs_n      <= 1'b1;
            din           <= 1'b0;
            rif.res_valid <= '0;
            rif.res_data  <= 12'd0;
            rif.res_ch    <= 3'd0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            addr          <= addr_nxt;
            cur           <= cur_nxt;
            prev          <= prev_nxt;
            last_grant    <= last_grant_nxt;
            adc_cs_n      <= (state_nxt != FRAME);
            din           <= din_nxt;
            rif.res_valid <= strobe ? (NUM_REQ'(1) << prev.tag) : '0;
            if (strobe) begin
                rif.res_data <= shreg;
                rif.res_ch   <= prev.ch;
            end
        end
    end

    // The 12 data bits occupy the last 12 rising edges of every frame.
    always_ff @(posedge adc_sck or negedge rst_n) begin
        if (!rst_n)
            shreg <= 12'd0;
        else if (state == FRAME && bit_cnt >= 4'd4)
            shreg <= {shreg[10:0], dout};
    end
endmodule

// File: tb/tb_adc_channel_arbiter.sv
// Bench for adc_channel_arbiter: ADC128S022 model with one-frame address pipeline,
// requester models and a per-requester queue of expected results.
module tb_adc_channel_arbiter;
    localparam int NREQ = 3;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    logic adc_sck = 1'b0;
    logic rst_n   = 1'b1;
    logic adc_cs_n, din;
    logic dout = 1'b0;

    adc_channel_arbiter_if #(.NUM_REQ(NREQ)) rif ();

    adc_channel_arbiter #(.NUM_REQ(NREQ)) dut (
        .adc_sck  (adc_sck),
        .rst_n    (rst_n),
        .rif      (rif),
        .adc_cs_n (adc_cs_n),
        .din      (din),
        .dout     (dout)
    );

    initial forever #5 adc_sck = ~adc_sck;

    int n_vec = 0, n_err = 0, cyc = 0;
    exp_t exp_q[NREQ][$];
    int   raise_q[NREQ][$];
    int   cmd_cnt[NREQ], cmd_gap[NREQ], issued[NREQ], done[NREQ], wait_cnt[NREQ];
    logic [2:0] cmd_ch[NREQ];
    int   stb_tag[$], stb_cyc[$], stb_lat[$];
    logic [2:0] addr_log[$];

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (ch)
            3'd0: return 12'h0F1;
            3'd1: return 12'h1E2;
            3'd2: return 12'h2D3;
            3'd3: return 12'hA5C;
            3'd4: return 12'h4B5;
            3'd5: return 12'h5A6;
            3'd6: return 12'h697;
            default: return 12'hF88;
        endcase
    endfunction

    // ADC: address on rising edges 2..4, data of the previous frame's address MSB-first on 4..15.
    initial begin
        int pcnt;
        logic [2:0]  fa, data_addr;
        logic [11:0] dv;
        pcnt = 0; fa = '0; data_addr = '0;
        forever begin
            @(posedge adc_sck);
            if (!adc_cs_n) begin
                if (pcnt >= 2 && pcnt <= 4) fa = {fa[1:0], din};
                if (pcnt == 4) addr_log.push_back(fa);
                if (pcnt == 15) begin
                    data_addr = fa;
                    pcnt = 0;
                end else pcnt++;
            end
            @(negedge adc_sck);
            #1;
            if (adc_cs_n) begin
                pcnt = 0;
                data_addr = '0;
            end
            dv = adc_val(data_addr);
            if (pcnt >= 4) dout = dv[15-pcnt];
            else dout = 1'b0;
        end
    end

    task automatic issue(input int i);
        rif.req_ch[3*i +: 3] = cmd_ch[i];
        exp_q[i].push_back('{ch: cmd_ch[i], data: adc_val(cmd_ch[i])});
        raise_q[i].push_back(cyc);
        issued[i]++;
    endtask

    // One clock: sample outputs after the negedge, score strobes, run requester models.
    task automatic tick();
        exp_t e;
        @(negedge adc_sck);
        #1;
        cyc++;
        if (rif.res_valid != '0) begin
            n_vec++;
            if ($countones(rif.res_valid) != 1) begin
                n_err++;
                $display("FAIL onehot: res_valid=%b, expected exactly one bit", rif.res_valid);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rif.res_valid[i]) begin
                stb_tag.push_back(i);
                stb_cyc.push_back(cyc);
                if (raise_q[i].size() > 0) stb_lat.push_back(cyc - raise_q[i].pop_front());
                else stb_lat.push_back(-1);
                done[i]++;
                n_vec++;
                if (exp_q[i].size() == 0) begin
                    n_err++;
                    $display("FAIL stray_strobe: res_valid[%0d] ch=%0d data=%h, expected no result", i, rif.res_ch, rif.res_data);
                end else begin
                    e = exp_q[i].pop_front();
                    if (rif.res_ch !== e.ch || rif.res_data !== e.data) begin
                        n_err++;
                        $display("FAIL result_%0d: got ch=%0d data=%h, expected ch=%0d data=%h", i, rif.res_ch, rif.res_data, e.ch, e.data);
                    end
                end
                if (cmd_gap[i] == 0 && issued[i] < cmd_cnt[i]) issue(i);
                else begin
                    rif.req[i] = 1'b0;
                    wait_cnt[i] = (cmd_gap[i] > 0) ? cmd_gap[i] - 1 : 0;
                end
            end else if (!rif.req[i] && issued[i] < cmd_cnt[i]) begin
                if (wait_cnt[i] > 0) wait_cnt[i]--;
                else begin
                    rif.req[i] = 1'b1;
                    issue(i);
                end
            end
        end
    endtask

    task automatic clear_bench();
        rif.req = '0;
        rif.req_ch = '0;
        for (int i = 0; i < NREQ; i++) begin
            cmd_cnt[i] = 0; cmd_gap[i] = 0; cmd_ch[i] = '0;
            issued[i] = 0; done[i] = 0; wait_cnt[i] = 0;
            exp_q[i].delete();
            raise_q[i].delete();
        end
        stb_tag.delete(); stb_cyc.delete(); stb_lat.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge adc_sck);
        #3 rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [2:0] ch, input int cnt, input int gap);
        cmd_ch[i] = ch; cmd_cnt[i] = cnt; cmd_gap[i] = gap;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NREQ; i++) if (done[i] < cmd_cnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_done(input int bound, input string name);
        int n = 0;
        while (!all_done() && n < bound) begin
            tick();
            n++;
        end
        n_vec++;
        if (!all_done()) begin
            n_err++;
            $display("FAIL %s_timeout: results still outstanding after %0d cycles, expected all delivered", name, bound);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge adc_sck);
        #1;
        n_vec += 6;
        if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b, expected 1", adc_cs_n); end
        if (din !== 1'b0) begin n_err++; $display("FAIL rst_din: got %b, expected 0", din); end
        if (rif.res_valid !== '0) begin n_err++; $display("FAIL rst_res_valid: got %b, expected 0", rif.res_valid); end
        if (rif.res_data !== 12'd0) begin n_err++; $display("FAIL rst_res_data: got %h, expected 000", rif.res_data); end
        if (rif.res_ch !== 3'd0) begin n_err++; $display("FAIL rst_res_ch: got %0d, expected 0", rif.res_ch); end
        if (rif.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", rif.busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int base;
        apply_reset();
        base = addr_log.size();
        set_req(0, 3'd3, 1, 0);
        run_until_done(100, "single");
        // raise tick + 1 = grant edge; result 32 negedges after that.
        n_vec++;
        if (stb_lat.size() != 1 || stb_lat[0] != 33) begin
            n_err++;
            $display("FAIL single_latency: got %0d strobes first lat %0d, expected 1 strobe lat 33", stb_lat.size(), (stb_lat.size() > 0) ? stb_lat[0] : -1);
        end
        n_vec++;
        if (addr_log.size() < base + 2 || addr_log[base] !== 3'd3 || addr_log[base+1] !== 3'd3) begin
            n_err++;
            $display("FAIL single_din: got %0d frames first addr %0d, expected addr 3 then flush addr 3", addr_log.size() - base, (addr_log.size() > base) ? addr_log[base] : 3'd0);
        end
        n_vec++;
        if (adc_cs_n !== 1'b1 || rif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got cs_n=%b busy=%b, expected cs_n=1 busy=0", adc_cs_n, rif.busy);
        end
        repeat (3) tick();
        n_vec++;
        if (adc_cs_n !== 1'b1 || rif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_stay_idle: got cs_n=%b busy=%b, expected cs_n=1 busy=0", adc_cs_n, rif.busy);
        end
    endtask

    task automatic test_all_three();
        apply_reset();
        set_req(0, 3'd1, 4, 1);
        set_req(1, 3'd3, 4, 1);
        set_req(2, 3'd4, 4, 1);
        run_until_done(400, "all_three");
        n_vec++;
        if (stb_tag.size() != 12) begin
            n_err++;
            $display("FAIL all_three_count: got %0d strobes, expected 12", stb_tag.size());
        end
        for (int k = 0; k < stb_tag.size() && k < 12; k++) begin
            n_vec++;
            if (stb_tag[k] != k % 3) begin
                n_err++;
                $display("FAIL all_three_order: strobe %0d got tag %0d, expected %0d", k, stb_tag[k], k % 3);
            end
            if (k > 0) begin
                n_vec++;
                if (stb_cyc[k] - stb_cyc[k-1] != 16) begin
                    n_err++;
                    $display("FAIL all_three_spacing: strobe %0d got gap %0d, expected 16", k, stb_cyc[k] - stb_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int n2 = 0;
        apply_reset();
        set_req(1, 3'd2, 8, 0);
        set_req(2, 3'd6, 3, 30);
        wait_cnt[2] = 20;
        run_until_done(1500, "fairness");
        for (int k = 0; k < stb_tag.size(); k++) begin
            if (stb_tag[k] == 2) begin
                n2++;
                n_vec++;
                // grant at the next arbitration edge (<=16 after request), result 32 later
                if (stb_lat[k] < 33 || stb_lat[k] > 48) begin
                    n_err++;
                    $display("FAIL fairness_latency: req2 strobe got lat %0d, expected 33..48", stb_lat[k]);
                end
            end
        end
        n_vec++;
        if (n2 != 3) begin n_err++; $display("FAIL fairness_count: got %0d req2 results, expected 3", n2); end
    endtask

    task automatic test_exclusion();
        apply_reset();
        set_req(0, 3'd5, 4, 0);
        run_until_done(300, "exclusion");
        for (int k = 1; k < stb_cyc.size(); k++) begin
            n_vec++;
            if (stb_cyc[k] - stb_cyc[k-1] != 33) begin
                n_err++;
                $display("FAIL exclusion_spacing: strobe %0d got gap %0d, expected 33", k, stb_cyc[k] - stb_cyc[k-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 3'd6, 1, 0);
        set_req(1, 3'd2, 1, 0);
        tick();
        repeat (24) tick();   // grant edge +23: frame 2, bit_cnt 7
        n_vec++;
        if (adc_cs_n !== 1'b0 || rif.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_in_frame: got cs_n=%b busy=%b, expected cs_n=0 busy=1", adc_cs_n, rif.busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (adc_cs_n !== 1'b1 || rif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_cs: got cs_n=%b busy=%b, expected cs_n=1 busy=0", adc_cs_n, rif.busy);
        end
        apply_reset();
        repeat (80) tick();
        n_vec++;
        if (stb_tag.size() != 0) begin
            n_err++;
            $display("FAIL mid_dropped: got %0d strobes after reset, expected 0", stb_tag.size());
        end
        set_req(2, 3'd1, 1, 0);
        run_until_done(100, "mid_fresh");
        n_vec++;
        if (stb_lat.size() != 1 || stb_lat[0] != 33) begin
            n_err++;
            $display("FAIL mid_fresh_latency: got %0d strobes lat %0d, expected 1 strobe lat 33", stb_lat.size(), (stb_lat.size() > 0) ? stb_lat[0] : -1);
        end
    endtask

    task automatic test_pipeline();
        apply_reset();
        set_req(0, 3'd0, 5, 1);
        set_req(1, 3'd7, 4, 23);
        run_until_done(1500, "pipeline");
        n_vec++;
        if (stb_tag.size() != 9) begin
            n_err++;
            $display("FAIL pipeline_count: got %0d strobes, expected 9", stb_tag.size());
        end
        repeat (40) tick();
        n_vec++;
        if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL pipeline_idle: got cs_n=%b, expected 1", adc_cs_n); end
    endtask

    initial begin
        clear_bench();
        test_reset();
        test_single();
        test_all_three();
        test_fairness();
        test_exclusion();
        test_reset_mid();
        test_pipeline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
